// File: rtl/rst_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : rst_sequencer
// Description : Reset release sequencer for the Knight's Tour robot. It sits
//               after the reset synchronizer and releases three reset domains
//               in a fixed order once the clock/supply qualifier (lock) has
//               been stable for STABLE_CYCLES:
//                 core -> peripherals (UART/SPI/IR) -> motor PWM
//               with STAGE_GAP cycles between the releases. If lock drops,
//               all three domains are re-asserted together.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Optional feature macro: RST_SEQ_WDOG_EN
//   Defined   : a RUN-state watchdog restarts the sequence when wdog_kick
//               is missing for WDOG_CYCLES cycles, and sets wdog_trip (sticky).
//   Undefined : wdog_kick is ignored and wdog_trip is tied low.
// ----------------------------------------------------------------------------
// Ports
//   clk          in   1  system clock
//   RST_n        in   1  asynchronous active-low reset
//   sync_rst_n   in   1  synchronized active-low reset, sampled on clk
//   lock         in   1  clock/supply stable qualifier, synchronous to clk
//   wdog_kick    in   1  one-cycle watchdog service pulse
//   rst_core_n   out  1  core-domain reset, active-low, registered
//   rst_periph_n out  1  peripheral-domain reset, active-low, registered
//   rst_motor_n  out  1  motor-domain reset, active-low, registered
//   seq_done     out  1  high while the sequence is in RUN
//   restart_cnt  out  4  saturating count of fault-driven restarts
//   wdog_trip    out  1  sticky watchdog-timeout flag
// ============================================================================
module rst_sequencer #(
    parameter int STABLE_CYCLES = 1024,
    parameter int STAGE_GAP     = 16,
    parameter int WDOG_CYCLES   = 1048576
) (
    input  logic       clk,
    input  logic       RST_n,
    input  logic       sync_rst_n,
    input  logic       lock,
    input  logic       wdog_kick,
    output logic       rst_core_n,
    output logic       rst_periph_n,
    output logic       rst_motor_n,
    output logic       seq_done,
    output logic [3:0] restart_cnt,
    output logic       wdog_trip
);

    // The shared stage counter must hold the longer of the two intervals.
    localparam int c_cnt_max = (STABLE_CYCLES > STAGE_GAP) ? STABLE_CYCLES : STAGE_GAP;
    localparam int c_cnt_w   = (c_cnt_max > 1) ? $clog2(c_cnt_max) : 1;
    localparam logic [c_cnt_w-1:0] c_stable_last = c_cnt_w'(STABLE_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_gap_last    = c_cnt_w'(STAGE_GAP - 1);

    // The motor release coincides with entry into RUN, so the motor stage has
    // no dwell time of its own: REL_PERIPH hands over directly to RUN.
    typedef enum logic [2:0] {
        HOLD        = 3'd0,
        WAIT_STABLE = 3'd1,
        REL_CORE    = 3'd2,
        REL_PERIPH  = 3'd3,
        RUN         = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic [c_cnt_w-1:0]   cnt_q, cnt_d;
    logic                 rst_core_n_q, rst_core_n_d;
    logic                 rst_periph_n_q, rst_periph_n_d;
    logic                 rst_motor_n_q, rst_motor_n_d;
    logic                 seq_done_q, seq_done_d;
    logic [3:0]           restart_cnt_q, restart_cnt_d;
    logic                 wdog_fire;
    logic                 fault;

`ifdef RST_SEQ_WDOG_EN
    localparam int c_wdog_w = $clog2(WDOG_CYCLES) + 1;
    localparam logic [c_wdog_w-1:0] c_wdog_last = c_wdog_w'(WDOG_CYCLES - 1);

    logic [c_wdog_w-1:0]  wdog_cnt_q, wdog_cnt_d;
    logic                 wdog_trip_q, wdog_trip_d;

    // A kick on the terminal cycle services the watchdog instead of firing.
    assign wdog_fire = (state_q == RUN) && !wdog_kick && (wdog_cnt_q == c_wdog_last);
`else
    logic [1:0] unused_wdog;

    assign unused_wdog = {wdog_kick, (WDOG_CYCLES > 0)};
    assign wdog_fire   = 1'b0;
`endif

    // Any loss of qualification outside HOLD aborts the sequence, and it
    // takes priority over a stage advance on the same edge.
    assign fault = (state_q != HOLD) && (!lock || wdog_fire);

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        rst_core_n_d   = rst_core_n_q;
        rst_periph_n_d = rst_periph_n_q;
        rst_motor_n_d  = rst_motor_n_q;
        seq_done_d     = seq_done_q;
        restart_cnt_d  = restart_cnt_q;
`ifdef RST_SEQ_WDOG_EN
        wdog_trip_d    = wdog_trip_q;
        wdog_cnt_d     = '0;
`endif

        if (!sync_rst_n) begin
            state_d        = HOLD;
            cnt_d          = '0;
            rst_core_n_d   = 1'b0;
            rst_periph_n_d = 1'b0;
            rst_motor_n_d  = 1'b0;
            seq_done_d     = 1'b0;
            restart_cnt_d  = 4'd0;
`ifdef RST_SEQ_WDOG_EN
            wdog_trip_d    = 1'b0;
`endif
        end else if (fault) begin
            state_d        = HOLD;
            cnt_d          = '0;
            rst_core_n_d   = 1'b0;
            rst_periph_n_d = 1'b0;
            rst_motor_n_d  = 1'b0;
            seq_done_d     = 1'b0;
            // Only restarts that pull an already running core back count.
            if (rst_core_n_q && (restart_cnt_q != 4'hF)) begin
                restart_cnt_d = restart_cnt_q + 4'd1;
            end
`ifdef RST_SEQ_WDOG_EN
            if (wdog_fire) begin
                wdog_trip_d = 1'b1;
            end
`endif
        end else begin
            case (state_q)
                HOLD: begin
                    if (lock) begin
                        state_d = WAIT_STABLE;
                        cnt_d   = '0;
                    end
                end
                WAIT_STABLE: begin
                    if (cnt_q == c_stable_last) begin
                        state_d      = REL_CORE;
                        cnt_d        = '0;
                        rst_core_n_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                REL_CORE: begin
                    if (cnt_q == c_gap_last) begin
                        state_d        = REL_PERIPH;
                        cnt_d          = '0;
                        rst_periph_n_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                REL_PERIPH: begin
                    if (cnt_q == c_gap_last) begin
                        state_d       = RUN;
                        cnt_d         = '0;
                        rst_motor_n_d = 1'b1;
                        seq_done_d    = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                RUN: begin
`ifdef RST_SEQ_WDOG_EN
                    wdog_cnt_d = wdog_kick ? '0 : (wdog_cnt_q + 1'b1);
`endif
                end
                default: begin
                    state_d        = HOLD;
                    cnt_d          = '0;
                    rst_core_n_d   = 1'b0;
                    rst_periph_n_d = 1'b0;
                    rst_motor_n_d  = 1'b0;
                    seq_done_d     = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge RST_n) begin
        if (!RST_n) begin
            state_q        <= HOLD;
            cnt_q          <= '0;
            rst_core_n_q   <= 1'b0;
            rst_periph_n_q <= 1'b0;
            rst_motor_n_q  <= 1'b0;
            seq_done_q     <= 1'b0;
            restart_cnt_q  <= 4'd0;
`ifdef RST_SEQ_WDOG_EN
            wdog_cnt_q     <= '0;
            wdog_trip_q    <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            rst_core_n_q   <= rst_core_n_d;
            rst_periph_n_q <= rst_periph_n_d;
            rst_motor_n_q  <= rst_motor_n_d;
            seq_done_q     <= seq_done_d;
            restart_cnt_q  <= restart_cnt_d;
`ifdef RST_SEQ_WDOG_EN
            wdog_cnt_q     <= wdog_cnt_d;
            wdog_trip_q    <= wdog_trip_d;
`endif
        end
    end

    assign rst_core_n   = rst_core_n_q;
    assign rst_periph_n = rst_periph_n_q;
    assign rst_motor_n  = rst_motor_n_q;
    assign seq_done     = seq_done_q;
    assign restart_cnt  = restart_cnt_q;
`ifdef RST_SEQ_WDOG_EN
    assign wdog_trip    = wdog_trip_q;
`else
    assign wdog_trip    = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rst_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_rst_sequencer
// Description : Self-checking bench for rst_sequencer (STABLE_CYCLES=8,
//               STAGE_GAP=4, WDOG_CYCLES=32). A reference model tracks the
//               number of qualified edges since the first lock-qualified
//               edge and derives every output from that elapsed time.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rst_sequencer;

    localparam int S     = 8;
    localparam int G     = 4;
    localparam int W     = 32;
    localparam int T_RUN = S + 2 * G;

    logic       clk = 1'b0;
    logic       RST_n;
    logic       sync_rst_n;
    logic       lock;
    logic       wdog_kick;
    logic       rst_core_n;
    logic       rst_periph_n;
    logic       rst_motor_n;
    logic       seq_done;
    logic [3:0] restart_cnt;
    logic       wdog_trip;

    int checks   = 0;
    int failures = 0;

    // Reference model: m_t = edges elapsed since qualification (-1 = held).
    int m_t       = -1;
    int m_restart = 0;
    int m_idle    = 0;
    bit m_trip    = 1'b0;

    typedef struct {
        bit         s;
        bit         l;
        int         n;
        logic [8:0] exp;
    } vec_t;

    vec_t tbl [11];

    rst_sequencer #(
        .STABLE_CYCLES (S),
        .STAGE_GAP     (G),
        .WDOG_CYCLES   (W)
    ) dut (
        .clk          (clk),
        .RST_n        (RST_n),
        .sync_rst_n   (sync_rst_n),
        .lock         (lock),
        .wdog_kick    (wdog_kick),
        .rst_core_n   (rst_core_n),
        .rst_periph_n (rst_periph_n),
        .rst_motor_n  (rst_motor_n),
        .seq_done     (seq_done),
        .restart_cnt  (restart_cnt),
        .wdog_trip    (wdog_trip)
    );

    always #5 clk = ~clk;

    function automatic logic [8:0] mk(bit c, bit p, bit m, bit d, int rc, bit tr);
        return {c, p, m, d, 4'(rc), tr};
    endfunction

    function automatic logic [8:0] dut_vec();
        return {rst_core_n, rst_periph_n, rst_motor_n, seq_done, restart_cnt, wdog_trip};
    endfunction

    function automatic logic [8:0] model_vec();
        return mk(m_t >= S, m_t >= S + G, m_t >= T_RUN, m_t >= T_RUN, m_restart, m_trip);
    endfunction

    task automatic check(string name, logic [8:0] exp);
        logic [8:0] got;
        got = dut_vec();
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got core/per/mot/done/rc/trip=%b expected %b at %0t",
                     name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_t       = -1;
        m_restart = 0;
        m_trip    = 1'b0;
        m_idle    = 0;
    endtask

    task automatic model_edge(bit s, bit l, bit k);
        bit flt;
        if (!s) begin
            model_reset();
            return;
        end
        if (m_t < 0) begin
            if (l) m_t = 0;
            m_idle = 0;
            return;
        end
        flt = !l;
`ifdef RST_SEQ_WDOG_EN
        if (m_t == T_RUN) begin
            if (k) m_idle = 0;
            else if (m_idle == W - 1) begin
                flt    = 1'b1;
                m_trip = 1'b1;
            end else m_idle++;
        end
`else
        if (k) m_idle = 0;
`endif
        if (flt) begin
            if (m_t >= S && m_restart < 15) m_restart++;
            m_t    = -1;
            m_idle = 0;
        end else if (m_t < T_RUN) begin
            m_t++;
        end
    endtask

    // Drive inputs, take one clock edge, compare against the model #1 later.
    task automatic step(bit s, bit l, bit k);
        sync_rst_n = s;
        lock       = l;
        wdog_kick  = k;
        @(posedge clk);
        model_edge(s, l, k);
        #1;
        check("model", model_vec());
    endtask

    task automatic run_up();
        repeat (T_RUN + 1) step(1'b1, 1'b1, 1'b0);
    endtask

    initial begin
        RST_n      = 1'b0;
        sync_rst_n = 1'b0;
        lock       = 1'b0;
        wdog_kick  = 1'b0;
        #12;
        check("reset_state", mk(0, 0, 0, 0, 0, 0));
        #1 RST_n = 1'b1;
        step(1'b0, 1'b0, 1'b0);

        // Release timeline and a RUN fault, driven from a vector table.
        tbl[0]  = '{1'b1, 1'b1, 1, mk(0, 0, 0, 0, 0, 0)};
        tbl[1]  = '{1'b1, 1'b1, 7, mk(0, 0, 0, 0, 0, 0)};
        tbl[2]  = '{1'b1, 1'b1, 1, mk(1, 0, 0, 0, 0, 0)};
        tbl[3]  = '{1'b1, 1'b1, 3, mk(1, 0, 0, 0, 0, 0)};
        tbl[4]  = '{1'b1, 1'b1, 1, mk(1, 1, 0, 0, 0, 0)};
        tbl[5]  = '{1'b1, 1'b1, 3, mk(1, 1, 0, 0, 0, 0)};
        tbl[6]  = '{1'b1, 1'b1, 1, mk(1, 1, 1, 1, 0, 0)};
        tbl[7]  = '{1'b1, 1'b1, 5, mk(1, 1, 1, 1, 0, 0)};
        tbl[8]  = '{1'b1, 1'b0, 1, mk(0, 0, 0, 0, 1, 0)};
        tbl[9]  = '{1'b1, 1'b0, 2, mk(0, 0, 0, 0, 1, 0)};
        tbl[10] = '{1'b0, 1'b1, 1, mk(0, 0, 0, 0, 0, 0)};
        for (int i = 0; i < 11; i++) begin
            repeat (tbl[i].n) step(tbl[i].s, tbl[i].l, 1'b0);
            check($sformatf("table_row%0d", i), tbl[i].exp);
        end

        // Lock glitch during WAIT_STABLE: back to HOLD, no restart counted.
        repeat (5) step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        check("glitch_hold", mk(0, 0, 0, 0, 0, 0));
        step(1'b1, 1'b1, 1'b0);
        repeat (7) step(1'b1, 1'b1, 1'b0);
        check("requal_core_low", mk(0, 0, 0, 0, 0, 0));
        step(1'b1, 1'b1, 1'b0);
        check("requal_core_rel", mk(1, 0, 0, 0, 0, 0));
        step(1'b0, 1'b1, 1'b0);

        // Lock drop at E0+13 (peripherals released), repeated to saturation.
        for (int i = 0; i < 16; i++) begin
            repeat (13) step(1'b1, 1'b1, 1'b0);
            check("pre_drop", mk(1, 1, 0, 0, (i < 15) ? i : 15, 0));
            step(1'b1, 1'b0, 1'b0);
            check($sformatf("drop%0d", i), mk(0, 0, 0, 0, (i + 1 < 15) ? i + 1 : 15, 0));
        end

        // Synchronous reset in RUN clears everything on that edge.
        run_up();
        check("run_sat", mk(1, 1, 1, 1, 15, 0));
        step(1'b0, 1'b1, 1'b0);
        check("sync_rst_run", mk(0, 0, 0, 0, 0, 0));

        // Asynchronous reset mid-cycle while in RUN with a nonzero count.
        run_up();
        step(1'b1, 1'b0, 1'b0);
        run_up();
        check("run_rc1", mk(1, 1, 1, 1, 1, 0));
        #2 RST_n = 1'b0;
        #1;
        check("async_rst", mk(0, 0, 0, 0, 0, 0));
        model_reset();
        #1 RST_n = 1'b1;

        // Watchdog behaviour in RUN.
        run_up();
`ifdef RST_SEQ_WDOG_EN
        repeat (W - 1) step(1'b1, 1'b1, 1'b0);
        check("wdog_pre", mk(1, 1, 1, 1, 0, 0));
        step(1'b1, 1'b1, 1'b0);
        check("wdog_fire", mk(0, 0, 0, 0, 1, 1));
        run_up();
        check("wdog_sticky", mk(1, 1, 1, 1, 1, 1));
        step(1'b0, 1'b1, 1'b0);
        run_up();
        for (int i = 0; i < 100; i++) step(1'b1, 1'b1, (i % 20) == 19);
        check("wdog_kicked", mk(1, 1, 1, 1, 0, 0));
`else
        repeat (2 * W) step(1'b1, 1'b1, 1'b0);
        check("no_wdog", mk(1, 1, 1, 1, 0, 0));
`endif

        // Randomized stimulus against the model.
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 199) != 0,
                 $urandom_range(0, 39) != 0,
                 $urandom_range(0, 24) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
